// File: rtl/dmem_cache_if.sv
`default_nettype none
// ============================================================================
// Module   : dmem_cache_if
// Purpose  : Groups the datapath-side (DM_*) request/response signals and the
//            handshaked main-memory bus (mem_*) used by dmem_cache.
// Modports : slave  - the cache: takes DM requests, drives the memory bus
//            master - the environment: pipeline MEM stage plus memory model
// Revision : 1.0  initial release
// ============================================================================
interface dmem_cache_if #(
    parameter int N = 64
);
    logic [N-1:0] DM_addr;
    logic [N-1:0] DM_writeData;
    logic         DM_readEnable;
    logic         DM_writeEnable;
    logic [N-1:0] DM_readData;
    logic         stall;
    logic         mem_req;
    logic         mem_we;
    logic [N-1:0] mem_addr;
    logic [N-1:0] mem_wdata;
    logic         mem_ack;
    logic [N-1:0] mem_rdata;

    modport slave (
        input  DM_addr, DM_writeData, DM_readEnable, DM_writeEnable,
        output DM_readData, stall,
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_ack, mem_rdata
    );

    modport master (
        output DM_addr, DM_writeData, DM_readEnable, DM_writeEnable,
        input  DM_readData, stall,
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_ack, mem_rdata
    );
endinterface
`default_nettype wire

// File: rtl/dmem_cache.sv
`default_nettype none
// ============================================================================
// Module   : dmem_cache
// Purpose  : Direct-mapped, write-through, one-word-per-line data cache that
//            sits between the pipeline MEM stage and a slow handshaked bus.
//            Load hits return data in the same cycle; misses and stores
//            stall the pipeline until the bus acknowledges.
// Ports    : clk        - clock, rising edge
//            reset      - asynchronous, active-high reset
//            bus        - dmem_cache_if.slave (DM_* request side, mem_* bus)
//            hit_count  - saturating count of load hits
//            miss_count - saturating count of load misses
// Revision : 1.0  initial release
// ============================================================================
module dmem_cache #(
    parameter int N     = 64,
    parameter int LINES = 16
) (
    input  logic        clk,
    input  logic        reset,
    dmem_cache_if.slave bus,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
);

    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = N - 3 - IDX_W;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RD_WAIT = 2'd1,
        S_WR_WAIT = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [LINES-1:0] r_valid;
    logic [TAG_W-1:0] r_tag  [LINES];
    logic [N-1:0]     r_data [LINES];

    logic [N-1:0] r_fill;      // word returned by the last fill, replayed in DONE
    logic         r_fill_op;   // DONE follows a load (not a store)
    logic         r_mem_req;
    logic         r_mem_we;
    logic [N-1:0] r_mem_addr;
    logic [N-1:0] r_mem_wdata;
    logic [31:0]  r_hit_count;
    logic [31:0]  r_miss_count;

    logic [IDX_W-1:0] w_idx;
    logic [TAG_W-1:0] w_tag;
    logic             w_hit;
    logic             w_load;
    logic             w_store;
    logic             w_stall;
    logic [N-1:0]     w_rdata;
    logic [N-1:0]     w_line_addr;
    logic             w_unused_ok;

    assign w_idx       = bus.DM_addr[3 +: IDX_W];
    assign w_tag       = bus.DM_addr[N-1 -: TAG_W];
    assign w_hit       = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    // Both enables high is a store; a load is only a pure read request.
    assign w_store     = bus.DM_writeEnable;
    assign w_load      = bus.DM_readEnable && !bus.DM_writeEnable;
    assign w_line_addr = {bus.DM_addr[N-1:3], 3'b000};
    assign w_unused_ok = ^bus.DM_addr[2:0];

    // ---------------- state register ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_next;
    end

    // ---------------- next state and pipeline-facing outputs ----------------
    always_comb begin
        w_state_next = r_state;
        w_stall      = 1'b0;
        w_rdata      = '0;
        case (r_state)
            S_IDLE: begin
                if (w_store) begin
                    w_stall      = 1'b1;
                    w_state_next = S_WR_WAIT;
                end else if (w_load) begin
                    if (w_hit) begin
                        w_rdata = r_data[w_idx];
                    end else begin
                        w_stall      = 1'b1;
                        w_state_next = S_RD_WAIT;
                    end
                end
            end
            S_RD_WAIT, S_WR_WAIT: begin
                w_stall = 1'b1;
                if (bus.mem_ack) w_state_next = S_DONE;
            end
            S_DONE: begin
                // Inputs are still those of the finished access; do not re-look-up.
                if (r_fill_op) w_rdata = r_fill;
                w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // ---------------- bus registers, valid bits, counters ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid      <= '0;
            r_fill       <= '0;
            r_fill_op    <= 1'b0;
            r_mem_req    <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_hit_count  <= '0;
            r_miss_count <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_store) begin
                        r_mem_req   <= 1'b1;
                        r_mem_we    <= 1'b1;
                        r_mem_addr  <= w_line_addr;
                        r_mem_wdata <= bus.DM_writeData;
                        r_fill_op   <= 1'b0;
                    end else if (w_load) begin
                        if (w_hit) begin
                            if (r_hit_count != 32'hFFFF_FFFF)
                                r_hit_count <= r_hit_count + 32'd1;
                        end else begin
                            r_mem_req  <= 1'b1;
                            r_mem_we   <= 1'b0;
                            r_mem_addr <= w_line_addr;
                            r_fill_op  <= 1'b1;
                            if (r_miss_count != 32'hFFFF_FFFF)
                                r_miss_count <= r_miss_count + 32'd1;
                        end
                    end
                end
                S_RD_WAIT: begin
                    if (bus.mem_ack) begin
                        r_valid[w_idx] <= 1'b1;
                        r_fill         <= bus.mem_rdata;
                        r_mem_req      <= 1'b0;
                    end
                end
                S_WR_WAIT: begin
                    if (bus.mem_ack) begin
                        r_mem_req <= 1'b0;
                        r_mem_we  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Tag/data storage needs no reset: a line is only observable once its
    // valid bit is set. After a reset the state is IDLE, so a stray ack
    // cannot write here.
    always_ff @(posedge clk) begin
        if (r_state == S_RD_WAIT && bus.mem_ack) begin
            r_tag[w_idx]  <= w_tag;
            r_data[w_idx] <= bus.mem_rdata;
        end else if (r_state == S_WR_WAIT && bus.mem_ack && w_hit) begin
            r_data[w_idx] <= bus.DM_writeData;   // write-through, no allocate on miss
        end
    end

    assign bus.stall       = w_stall;
    assign bus.DM_readData = w_rdata;
    assign bus.mem_req     = r_mem_req;
    assign bus.mem_we      = r_mem_we;
    assign bus.mem_addr    = r_mem_addr;
    assign bus.mem_wdata   = r_mem_wdata;
    assign hit_count       = r_hit_count;
    assign miss_count      = r_miss_count;

endmodule
`default_nettype wire

// File: tb/tb_dmem_cache.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_cache
// Purpose  : Self-checking bench for dmem_cache: directed scenarios plus a
//            randomized run against a behavioural cache/memory model.
// Revision : 1.0  initial release
// ============================================================================
module tb_dmem_cache;

    localparam int N     = 64;
    localparam int LINES = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] hit_count;
    logic [31:0] miss_count;

    int tests = 0;
    int fails = 0;

    dmem_cache_if #(.N(N)) dm ();

    dmem_cache #(.N(N), .LINES(LINES)) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (dm.slave),
        .hit_count  (hit_count),
        .miss_count (miss_count)
    );

    always #5 clk = ~clk;

    // Reference model: memory contents by word address, and which word
    // address each direct-mapped slot currently holds.
    logic [63:0] mm [longint];
    bit          cv [LINES];
    longint      cw [LINES];
    int          m_hits, m_misses;

    // Drive one access and observe it until the pipeline is released.
    // mem_ack is raised in the wait_n-th cycle that mem_req is seen high.
    task automatic access(input logic re, input logic we, input logic [63:0] addr,
                          input logic [63:0] wdata, input int wait_n, input logic [63:0] rdata,
                          output int stall_n, output logic [63:0] rd_out,
                          output logic bus_seen, output logic bus_we,
                          output logic [63:0] bus_addr, output logic [63:0] bus_wdata,
                          output logic timeout);
        int  req_n;
        bit  done;
        stall_n = 0; req_n = 0; done = 0;
        rd_out = '0; bus_seen = 0; bus_we = 0; bus_addr = '0; bus_wdata = '0;
        @(posedge clk); #1;
        dm.DM_addr = addr; dm.DM_writeData = wdata;
        dm.DM_readEnable = re; dm.DM_writeEnable = we;
        for (int c = 0; c < 100 && !done; c++) begin
            @(negedge clk);
            if (dm.mem_req) begin
                req_n++;
                if (!bus_seen) begin
                    bus_we = dm.mem_we; bus_addr = dm.mem_addr; bus_wdata = dm.mem_wdata;
                end
                bus_seen = 1;
                if (req_n == wait_n) begin dm.mem_ack = 1'b1; dm.mem_rdata = rdata; end
            end
            if (dm.stall) stall_n++;
            else begin rd_out = dm.DM_readData; done = 1; end
            @(posedge clk); #1;
            dm.mem_ack = 1'b0;
        end
        dm.DM_readEnable = 0; dm.DM_writeEnable = 0;
        timeout = !done;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        dm.DM_addr = '0; dm.DM_writeData = '0; dm.DM_readEnable = 0; dm.DM_writeEnable = 0;
        dm.mem_ack = 0; dm.mem_rdata = '0;
        repeat (2) @(negedge clk);
        tests++; if (dm.stall !== 1'b0) begin fails++; $display("FAIL reset_stall: got %b want 0", dm.stall); end
        tests++; if (dm.mem_req !== 1'b0 || dm.mem_we !== 1'b0) begin fails++; $display("FAIL reset_req: got req=%b we=%b want 0 0", dm.mem_req, dm.mem_we); end
        tests++; if (dm.mem_addr !== 64'd0 || dm.mem_wdata !== 64'd0) begin fails++; $display("FAIL reset_bus: got addr=%h wdata=%h want 0", dm.mem_addr, dm.mem_wdata); end
        tests++; if (dm.DM_readData !== 64'd0) begin fails++; $display("FAIL reset_rdata: got %h want 0", dm.DM_readData); end
        tests++; if (hit_count !== 32'd0 || miss_count !== 32'd0) begin fails++; $display("FAIL reset_counts: got %0d/%0d want 0/0", hit_count, miss_count); end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_load_miss();
        int sn; logic [63:0] rd, ba, bw; logic bs, bwe, to;
        access(1, 0, 64'h100, '0, 2, 64'hDEAD, sn, rd, bs, bwe, ba, bw, to);
        @(negedge clk);
        tests++; if (to || sn != 3) begin fails++; $display("FAIL miss_stall_cycles: got %0d (timeout=%b) want 3", sn, to); end
        tests++; if (rd !== 64'hDEAD) begin fails++; $display("FAIL miss_rdata: got %h want dead", rd); end
        tests++; if (!bs || bwe !== 1'b0 || ba !== 64'h100) begin fails++; $display("FAIL miss_bus: got seen=%b we=%b addr=%h want 1 0 100", bs, bwe, ba); end
        tests++; if (miss_count !== 32'd1) begin fails++; $display("FAIL miss_count: got %0d want 1", miss_count); end
    endtask

    task automatic test_load_hit();
        int sn; logic [63:0] rd, ba, bw; logic bs, bwe, to;
        access(1, 0, 64'h104, '0, 1, 64'h0, sn, rd, bs, bwe, ba, bw, to);   // low bits ignored
        @(negedge clk);
        tests++; if (to || sn != 0) begin fails++; $display("FAIL hit_stall: got %0d want 0", sn); end
        tests++; if (rd !== 64'hDEAD) begin fails++; $display("FAIL hit_rdata: got %h want dead", rd); end
        tests++; if (bs !== 1'b0) begin fails++; $display("FAIL hit_no_bus: got mem_req seen=%b want 0", bs); end
        tests++; if (hit_count !== 32'd1) begin fails++; $display("FAIL hit_count: got %0d want 1", hit_count); end
    endtask

    task automatic test_store();
        int sn; logic [63:0] rd, ba, bw; logic bs, bwe, to;
        access(0, 1, 64'h100, 64'hBEEF, 1, '0, sn, rd, bs, bwe, ba, bw, to);
        tests++; if (to || sn != 2) begin fails++; $display("FAIL store_stall: got %0d want 2", sn); end
        tests++; if (bwe !== 1'b1 || ba !== 64'h100 || bw !== 64'hBEEF) begin fails++; $display("FAIL store_bus: got we=%b addr=%h wdata=%h want 1 100 beef", bwe, ba, bw); end
        access(1, 0, 64'h100, '0, 1, 64'h0, sn, rd, bs, bwe, ba, bw, to);
        @(negedge clk);
        tests++; if (sn != 0 || rd !== 64'hBEEF) begin fails++; $display("FAIL store_then_hit: got stall=%0d rdata=%h want 0 beef", sn, rd); end
        tests++; if (hit_count !== 32'd2 || miss_count !== 32'd1) begin fails++; $display("FAIL store_counts: got %0d/%0d want 2/1", hit_count, miss_count); end
    endtask

    task automatic test_eviction();
        int sn; logic [63:0] rd, ba, bw; logic bs, bwe, to;
        access(1, 0, 64'h100 + 8*LINES, '0, 1, 64'h1111, sn, rd, bs, bwe, ba, bw, to);
        tests++; if (sn != 2 || rd !== 64'h1111 || ba !== 64'h100 + 8*LINES) begin fails++; $display("FAIL evict_conflict_miss: got stall=%0d rdata=%h addr=%h want 2 1111 %h", sn, rd, ba, 64'h100 + 8*LINES); end
        access(1, 0, 64'h100, '0, 1, 64'hBEEF, sn, rd, bs, bwe, ba, bw, to);
        tests++; if (sn != 2 || rd !== 64'hBEEF) begin fails++; $display("FAIL evict_remiss: got stall=%0d rdata=%h want 2 beef", sn, rd); end
    endtask

    task automatic test_no_allocate();
        int sn; logic [63:0] rd, ba, bw; logic bs, bwe, to;
        access(0, 1, 64'h200, 64'h5555, 1, '0, sn, rd, bs, bwe, ba, bw, to);
        access(1, 0, 64'h200, '0, 1, 64'h5555, sn, rd, bs, bwe, ba, bw, to);
        tests++; if (sn != 2 || !bs || rd !== 64'h5555) begin fails++; $display("FAIL no_allocate: got stall=%0d bus=%b rdata=%h want 2 1 5555", sn, bs, rd); end
    endtask

    task automatic test_both_enables();
        int sn; logic [63:0] rd, ba, bw; logic bs, bwe, to;
        logic [31:0] h0, m0;
        h0 = hit_count; m0 = miss_count;
        access(1, 1, 64'h100, 64'h7777, 1, '0, sn, rd, bs, bwe, ba, bw, to);
        @(negedge clk);
        tests++; if (bwe !== 1'b1 || bw !== 64'h7777 || sn != 2) begin fails++; $display("FAIL both_is_store: got we=%b wdata=%h stall=%0d want 1 7777 2", bwe, bw, sn); end
        tests++; if (hit_count !== h0 || miss_count !== m0) begin fails++; $display("FAIL both_counts: got %0d/%0d want %0d/%0d", hit_count, miss_count, h0, m0); end
    endtask

    task automatic test_random();
        int sn; logic [63:0] rd, ba, bw, addr, wd, exp; logic bs, bwe, to;
        longint w; int idx, wn, kind; bit hit;
        // start from a clean cache so the model and DUT agree exactly
        reset = 1'b1; @(negedge clk); reset = 1'b0; @(negedge clk);
        for (int i = 0; i < LINES; i++) cv[i] = 0;
        m_hits = 0; m_misses = 0;
        for (int n = 0; n < 300; n++) begin
            w    = longint'($urandom_range(0, 4*LINES-1));
            addr = 64'(w) * 8 + 64'($urandom_range(0, 7));
            idx  = int'(w % LINES);
            hit  = cv[idx] && cw[idx] == w;
            wn   = $urandom_range(1, 3);
            kind = $urandom_range(0, 9);
            if (!mm.exists(w)) mm[w] = {$urandom, $urandom};
            if (kind < 6) begin
                exp = mm[w];
                access(1, 0, addr, '0, wn, exp, sn, rd, bs, bwe, ba, bw, to);
                tests++; if (to || sn != (hit ? 0 : wn + 1)) begin fails++; $display("FAIL rnd_load_stall n=%0d: got %0d want %0d", n, sn, hit ? 0 : wn + 1); end
                tests++; if (rd !== exp) begin fails++; $display("FAIL rnd_load_data n=%0d: got %h want %h", n, rd, exp); end
                if (!hit) begin
                    tests++; if (!bs || bwe !== 1'b0 || ba !== 64'(w) * 8) begin fails++; $display("FAIL rnd_fill_bus n=%0d: got seen=%b we=%b addr=%h want 1 0 %h", n, bs, bwe, ba, 64'(w) * 8); end
                    cv[idx] = 1; cw[idx] = w; m_misses++;
                end else m_hits++;
            end else begin
                wd = {$urandom, $urandom};
                access(kind == 9, 1, addr, wd, wn, '0, sn, rd, bs, bwe, ba, bw, to);
                tests++; if (to || sn != wn + 1) begin fails++; $display("FAIL rnd_store_stall n=%0d: got %0d want %0d", n, sn, wn + 1); end
                tests++; if (bwe !== 1'b1 || ba !== 64'(w) * 8 || bw !== wd) begin fails++; $display("FAIL rnd_store_bus n=%0d: got we=%b addr=%h wdata=%h want 1 %h %h", n, bwe, ba, bw, 64'(w) * 8, wd); end
                mm[w] = wd;
            end
        end
        @(negedge clk);
        tests++; if (hit_count !== 32'(m_hits) || miss_count !== 32'(m_misses)) begin fails++; $display("FAIL rnd_counts: got %0d/%0d want %0d/%0d", hit_count, miss_count, m_hits, m_misses); end
    endtask

    task automatic test_reset_mid();
        int sn; logic [63:0] rd, ba, bw; logic bs, bwe, to;
        bit seen = 0;
        // line 0x100 is cached before this point; start a miss on another line
        access(1, 0, 64'h100, '0, 1, 64'hABCD, sn, rd, bs, bwe, ba, bw, to);
        @(posedge clk); #1;
        dm.DM_addr = 64'h308; dm.DM_readEnable = 1;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge clk);
            if (dm.mem_req) seen = 1;
        end
        tests++; if (!seen) begin fails++; $display("FAIL mid_req_seen: got mem_req=0 want 1"); end
        reset = 1'b1; dm.DM_readEnable = 0;
        #1;
        tests++; if (dm.mem_req !== 1'b0 || dm.stall !== 1'b0) begin fails++; $display("FAIL mid_reset_async: got req=%b stall=%b want 0 0", dm.mem_req, dm.stall); end
        @(negedge clk); reset = 1'b0;
        @(negedge clk); dm.mem_ack = 1'b1; dm.mem_rdata = 64'h9999;
        @(negedge clk); dm.mem_ack = 1'b0;
        tests++; if (dm.mem_req !== 1'b0 || dm.stall !== 1'b0 || miss_count !== 32'd0) begin fails++; $display("FAIL mid_stray_ack: got req=%b stall=%b misses=%0d want 0 0 0", dm.mem_req, dm.stall, miss_count); end
        access(1, 0, 64'h308, '0, 1, 64'h4444, sn, rd, bs, bwe, ba, bw, to);
        tests++; if (sn != 2 || rd !== 64'h4444) begin fails++; $display("FAIL mid_line_invalid: got stall=%0d rdata=%h want 2 4444", sn, rd); end
        access(1, 0, 64'h100, '0, 1, 64'hABCD, sn, rd, bs, bwe, ba, bw, to);
        tests++; if (sn != 2) begin fails++; $display("FAIL mid_all_invalid: got stall=%0d want 2", sn); end
    endtask

    initial begin
        test_reset();
        test_load_miss();
        test_load_hit();
        test_store();
        test_eviction();
        test_no_allocate();
        test_both_enables();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
